// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and a
// saturating increment used by every counter so none of them can wrap.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        FILTER    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } seq_state_e;

    localparam int LOSS_CNT_W = 16;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
        return (value >= limit) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the PLL lock indication into the refclk domain.
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic lock_s
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign lock_s = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: pulses the PLL reset, filters lock, then releases domain resets in order.
// Define PLL_SEQ_LOCK_LOSS_CNT_EN to add the 16-bit lock_loss_cnt output.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_DOMAINS         = 4,
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_FILTER_CYCLES  = 1024,
    parameter int DOMAIN_GAP_CYCLES   = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                                 refclk,
    input  logic                                 rst,
    input  logic                                 pll_locked,
    input  logic                                 relock_req,
    output logic                                 pll_rst,
    output logic [NUM_DOMAINS-1:0]               domain_rst,
    output logic                                 ready,
    output logic                                 fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_count
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W-1:0]                lock_loss_cnt
`endif
);

    localparam int PULSE_W = $clog2(RST_PULSE_CYCLES) + 1;
    localparam int FILT_W  = $clog2(LOCK_FILTER_CYCLES) + 1;
    localparam int GAP_W   = $clog2(DOMAIN_GAP_CYCLES) + 1;
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
    localparam int IDX_W   = $clog2(NUM_DOMAINS) + 1;
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [NUM_DOMAINS-1:0] DOM_ALL = {NUM_DOMAINS{1'b1}};
    localparam logic [NUM_DOMAINS-1:0] DOM_ONE = NUM_DOMAINS'(1);

    logic lock_s;

    pll_lock_sync u_lock_sync (
        .clk      (refclk),
        .rst      (rst),
        .async_in (pll_locked),
        .lock_s   (lock_s)
    );

    seq_state_e             state_q, state_d;
    logic [PULSE_W-1:0]     pulse_cnt_q, pulse_cnt_d;
    logic [FILT_W-1:0]      filt_cnt_q, filt_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;

    logic pulse_done;
    logic timeout;

    assign pulse_done = (pulse_cnt_q >= PULSE_W'(RST_PULSE_CYCLES - 1));
    assign timeout    = (tmo_cnt_q >= TMO_W'(LOCK_TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        pulse_cnt_d  = pulse_cnt_q;
        filt_cnt_d   = filt_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        idx_d        = idx_q;
        tmo_cnt_d    = tmo_cnt_q;
        retry_d      = retry_q;
        pll_rst_d    = pll_rst_q;
        domain_rst_d = domain_rst_q;
        ready_d      = ready_q;
        fault_d      = fault_q;

        case (state_q)
            PLL_RST: begin
                pll_rst_d    = 1'b1;
                domain_rst_d = DOM_ALL;
                ready_d      = 1'b0;
                if (pulse_done) begin
                    state_d     = WAIT_LOCK;
                    pll_rst_d   = 1'b0;
                    pulse_cnt_d = '0;
                    tmo_cnt_d   = '0;
                end else begin
                    pulse_cnt_d = PULSE_W'(sat_inc(32'(pulse_cnt_q), 32'(RST_PULSE_CYCLES)));
                end
            end

            WAIT_LOCK, FILTER: begin
                // The timeout keeps running across FILTER->WAIT_LOCK drops so a flapping lock still expires.
                tmo_cnt_d = TMO_W'(sat_inc(32'(tmo_cnt_q), 32'(LOCK_TIMEOUT_CYCLES)));
                if (timeout) begin
                    pll_rst_d = 1'b1;
                    if (retry_q < RETRY_W'(MAX_RETRIES)) begin
                        retry_d     = retry_q + RETRY_W'(1);
                        state_d     = PLL_RST;
                        pulse_cnt_d = '0;
                    end else begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end
                end else if (state_q == WAIT_LOCK) begin
                    if (lock_s) begin
                        state_d    = FILTER;
                        filt_cnt_d = FILT_W'(1);
                    end
                end else if (filt_cnt_q >= FILT_W'(LOCK_FILTER_CYCLES)) begin
                    state_d      = RELEASE;
                    domain_rst_d = DOM_ALL & ~DOM_ONE;
                    idx_d        = IDX_W'(1);
                    gap_cnt_d    = '0;
                end else if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else begin
                    filt_cnt_d = FILT_W'(sat_inc(32'(filt_cnt_q), 32'(LOCK_FILTER_CYCLES)));
                end
            end

            RELEASE, RUN: begin
                // Lock loss and relock_req share one path, so a coincidence is a single re-sequence.
                if (!lock_s || relock_req) begin
                    state_d      = PLL_RST;
                    pll_rst_d    = 1'b1;
                    domain_rst_d = DOM_ALL;
                    ready_d      = 1'b0;
                    pulse_cnt_d  = '0;
                end else if (state_q == RELEASE) begin
                    if (idx_q >= IDX_W'(NUM_DOMAINS)) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                        retry_d = '0;
                    end else if (gap_cnt_q >= GAP_W'(DOMAIN_GAP_CYCLES - 1)) begin
                        domain_rst_d = domain_rst_q & ~(DOM_ONE << idx_q);
                        idx_d        = idx_q + IDX_W'(1);
                        gap_cnt_d    = '0;
                    end else begin
                        gap_cnt_d = GAP_W'(sat_inc(32'(gap_cnt_q), 32'(DOMAIN_GAP_CYCLES)));
                    end
                end
            end

            FAULT: begin
                pll_rst_d    = 1'b1;
                domain_rst_d = DOM_ALL;
                ready_d      = 1'b0;
                fault_d      = 1'b1;
                if (relock_req) begin
                    fault_d     = 1'b0;
                    retry_d     = '0;
                    state_d     = PLL_RST;
                    pulse_cnt_d = '0;
                end
            end

            default: begin
                state_d      = PLL_RST;
                pll_rst_d    = 1'b1;
                domain_rst_d = DOM_ALL;
                ready_d      = 1'b0;
                pulse_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q      <= PLL_RST;
            pulse_cnt_q  <= '0;
            filt_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            idx_q        <= '0;
            tmo_cnt_q    <= '0;
            retry_q      <= '0;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= DOM_ALL;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pulse_cnt_q  <= pulse_cnt_d;
            filt_cnt_q   <= filt_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            idx_q        <= idx_d;
            tmo_cnt_q    <= tmo_cnt_d;
            retry_q      <= retry_d;
            pll_rst_q    <= pll_rst_d;
            domain_rst_q <= domain_rst_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign domain_rst  = domain_rst_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;

`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
    logic                  lock_lost;
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    assign lock_lost = ((state_q == RELEASE) || (state_q == RUN)) && !lock_s;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (lock_lost) begin
            loss_cnt_d = LOSS_CNT_W'(sat_inc(32'(loss_cnt_q), 32'hFFFF));
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters; cycle k is the
// k-th refclk period after rst is released, sampled on the falling edge.
module tb_pll_reset_sequencer;
    import pll_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic [3:0] domain_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
    logic [15:0] lock_loss_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .NUM_DOMAINS         (4),
        .RST_PULSE_CYCLES    (4),
        .LOCK_FILTER_CYCLES  (8),
        .DOMAIN_GAP_CYCLES   (2),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2)
    ) dut (
        .refclk      (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .pll_rst     (pll_rst),
        .domain_rst  (domain_rst),
        .ready       (ready),
        .fault       (fault),
        .retry_count (retry_count)
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    // Expected domain_rst when domain 0 is released in cycle rel (gap 2, four domains).
    function automatic logic [3:0] exp_dom(input int k, input int rel);
        if (k < rel)          return 4'hF;
        else if (k < rel + 2) return 4'hE;
        else if (k < rel + 4) return 4'hC;
        else if (k < rel + 6) return 4'h8;
        else                  return 4'h0;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst        = 1'b1;
        pll_locked = 1'b1;
        relock_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (pll_rst !== 1'b1) begin n_errors++; $display("FAIL reset pll_rst: got %b expected 1", pll_rst); end
        n_checks++;
        if (domain_rst !== 4'hF) begin n_errors++; $display("FAIL reset domain_rst: got %h expected F", domain_rst); end
        n_checks++;
        if (ready !== 1'b0) begin n_errors++; $display("FAIL reset ready: got %b expected 0", ready); end
        n_checks++;
        if (fault !== 1'b0) begin n_errors++; $display("FAIL reset fault: got %b expected 0", fault); end
        n_checks++;
        if (retry_count !== 2'd0) begin n_errors++; $display("FAIL reset retry_count: got %0d expected 0", retry_count); end
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
        n_checks++;
        if (lock_loss_cnt !== 16'd0) begin n_errors++; $display("FAIL reset lock_loss_cnt: got %0d expected 0", lock_loss_cnt); end
`endif
    endtask

    task automatic test_nominal();
        do_reset();
        for (int k = 0; k <= 31; k++) begin
            pll_locked = (k >= 10);
            n_checks++;
            if (pll_rst !== (k < 4)) begin n_errors++; $display("FAIL nominal pll_rst cyc %0d: got %b expected %b", k, pll_rst, (k < 4)); end
            n_checks++;
            if (domain_rst !== exp_dom(k, 21)) begin n_errors++; $display("FAIL nominal domain_rst cyc %0d: got %h expected %h", k, domain_rst, exp_dom(k, 21)); end
            n_checks++;
            if (ready !== (k >= 28)) begin n_errors++; $display("FAIL nominal ready cyc %0d: got %b expected %b", k, ready, (k >= 28)); end
            n_checks++;
            if (retry_count !== 2'd0) begin n_errors++; $display("FAIL nominal retry_count cyc %0d: got %0d expected 0", k, retry_count); end
            next_cycle();
        end
    endtask

    task automatic test_glitchy_lock();
        do_reset();
        for (int k = 0; k <= 35; k++) begin
            pll_locked = (k >= 10 && k < 15) || (k >= 16);
            n_checks++;
            if (domain_rst !== exp_dom(k, 27)) begin n_errors++; $display("FAIL glitchy domain_rst cyc %0d: got %h expected %h", k, domain_rst, exp_dom(k, 27)); end
            n_checks++;
            if (ready !== (k >= 34)) begin n_errors++; $display("FAIL glitchy ready cyc %0d: got %b expected %b", k, ready, (k >= 34)); end
            n_checks++;
            if (retry_count !== 2'd0) begin n_errors++; $display("FAIL glitchy retry_count cyc %0d: got %0d expected 0", k, retry_count); end
            next_cycle();
        end
    endtask

    task automatic test_timeout();
        logic       e_prst;
        logic       e_fault;
        logic [1:0] e_retry;
        do_reset();
        for (int k = 0; k <= 116; k++) begin
            // The request at cycle 20 lands in WAIT_LOCK and must be ignored.
            relock_req = (k == 20) || (k == 110);
            e_prst  = (k < 4) || (k >= 36 && k < 40) || (k >= 72 && k < 76) || (k >= 108 && k < 115);
            e_fault = (k >= 108 && k <= 110);
            e_retry = (k < 36) ? 2'd0 : (k < 72) ? 2'd1 : (k <= 110) ? 2'd2 : 2'd0;
            n_checks++;
            if (pll_rst !== e_prst) begin n_errors++; $display("FAIL timeout pll_rst cyc %0d: got %b expected %b", k, pll_rst, e_prst); end
            n_checks++;
            if (fault !== e_fault) begin n_errors++; $display("FAIL timeout fault cyc %0d: got %b expected %b", k, fault, e_fault); end
            n_checks++;
            if (retry_count !== e_retry) begin n_errors++; $display("FAIL timeout retry_count cyc %0d: got %0d expected %0d", k, retry_count, e_retry); end
            n_checks++;
            if (domain_rst !== 4'hF) begin n_errors++; $display("FAIL timeout domain_rst cyc %0d: got %h expected F", k, domain_rst); end
            next_cycle();
        end
        relock_req = 1'b0;
    endtask

    // Lock drop and/or relock_req take effect at the edge of cycle 32 from RUN;
    // either way exactly one re-sequence starts in cycle 33.
    task automatic test_resequence(input bit drop, input bit req, input string name);
        logic [3:0] e_dom;
        logic       e_ready;
        logic       e_prst;
        do_reset();
        for (int k = 0; k <= 56; k++) begin
            pll_locked = (k >= 10) && !(drop && k >= 30 && k < 33);
            relock_req = req && (k == 32);
            e_dom   = (k < 33) ? exp_dom(k, 21) : exp_dom(k, 46);
            e_ready = (k >= 28 && k < 33) || (k >= 53);
            e_prst  = (k < 4) || (k >= 33 && k < 37);
            n_checks++;
            if (domain_rst !== e_dom) begin n_errors++; $display("FAIL %s domain_rst cyc %0d: got %h expected %h", name, k, domain_rst, e_dom); end
            n_checks++;
            if (ready !== e_ready) begin n_errors++; $display("FAIL %s ready cyc %0d: got %b expected %b", name, k, ready, e_ready); end
            n_checks++;
            if (pll_rst !== e_prst) begin n_errors++; $display("FAIL %s pll_rst cyc %0d: got %b expected %b", name, k, pll_rst, e_prst); end
            n_checks++;
            if (retry_count !== 2'd0) begin n_errors++; $display("FAIL %s retry_count cyc %0d: got %0d expected 0", name, k, retry_count); end
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
            n_checks++;
            if (lock_loss_cnt !== ((k >= 33 && drop) ? 16'd1 : 16'd0)) begin
                n_errors++;
                $display("FAIL %s lock_loss_cnt cyc %0d: got %0d expected %0d", name, k, lock_loss_cnt, (k >= 33 && drop) ? 1 : 0);
            end
`endif
            next_cycle();
        end
        relock_req = 1'b0;
    endtask

    task automatic test_rst_in_release();
        do_reset();
        for (int k = 0; k <= 23; k++) begin
            pll_locked = (k >= 10);
            if (k < 23) next_cycle();
        end
        n_checks++;
        if (domain_rst !== 4'hC) begin n_errors++; $display("FAIL rst_release pre domain_rst: got %h expected C", domain_rst); end
        rst = 1'b1;
        next_cycle();
        n_checks++;
        if (domain_rst !== 4'hF) begin n_errors++; $display("FAIL rst_release domain_rst: got %h expected F", domain_rst); end
        n_checks++;
        if (pll_rst !== 1'b1) begin n_errors++; $display("FAIL rst_release pll_rst: got %b expected 1", pll_rst); end
        n_checks++;
        if (ready !== 1'b0) begin n_errors++; $display("FAIL rst_release ready: got %b expected 0", ready); end
        n_checks++;
        if (dut.state_q !== PLL_RST) begin n_errors++; $display("FAIL rst_release state: got %0d expected %0d", dut.state_q, PLL_RST); end
        rst = 1'b0;
        // pll_locked stays high; the cleared synchronizer makes lock_s appear in cycle 2.
        for (int j = 0; j <= 20; j++) begin
            n_checks++;
            if (pll_rst !== (j < 4)) begin n_errors++; $display("FAIL rst_release resequence pll_rst cyc %0d: got %b expected %b", j, pll_rst, (j < 4)); end
            n_checks++;
            if (domain_rst !== exp_dom(j, 13)) begin n_errors++; $display("FAIL rst_release resequence domain_rst cyc %0d: got %h expected %h", j, domain_rst, exp_dom(j, 13)); end
            n_checks++;
            if (ready !== (j >= 20)) begin n_errors++; $display("FAIL rst_release resequence ready cyc %0d: got %b expected %b", j, ready, (j >= 20)); end
            next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        test_reset();
        test_nominal();
        test_glitchy_lock();
        test_timeout();
        test_resequence(1'b1, 1'b0, "lock_loss");
        test_resequence(1'b0, 1'b1, "relock_run");
        test_resequence(1'b1, 1'b1, "loss_and_relock");
        test_rst_in_release();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Supervises the fabric PLL: drives the PLL reset, qualifies its lock output, then releases per-clock-domain resets in a fixed order.
- Retries on lock timeout and re-sequences on loss of lock.
- Sits between the board reset / PLL instance and the downstream clock-domain reset synchronizers (outclk_0..outclk_3 consumers).
- Runs on the PLL reference clock, so it operates while the PLL is unlocked.

Parameters:
- NUM_DOMAINS, 4: number of downstream domain resets.
- RST_PULSE_CYCLES, 16: cycles pll_rst is held high per attempt.
- LOCK_FILTER_CYCLES, 1024: consecutive synchronized-lock cycles required before release.
- DOMAIN_GAP_CYCLES, 8: cycles between successive domain releases.
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK/FILTER per attempt.
- MAX_RETRIES, 3: timeout retries before FAULT.

Ports:
- refclk  in  1  reference clock; all logic runs on it.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL locked, asynchronous to refclk.
- relock_req  in  1  single-cycle software request to re-sequence or clear a fault.
- pll_rst  out  1  PLL reset, active high.
- domain_rst  out  NUM_DOMAINS  per-domain reset, active high; bit 0 released first.
- ready  out  1  high only in RUN.
- fault  out  1  sticky fault flag.
- retry_count  out  $clog2(MAX_RETRIES+1)  timeout retries in the current sequence.

Behaviour:
- Clock and reset: one clock, refclk. Reset rst is synchronous and active-high.
- Reset values (rst high): state=PLL_RST, pll_rst=1, domain_rst=all 1, ready=0, fault=0, retry_count=0, all counters 0. All outputs are registered.
- pll_locked passes through a 2-FF synchronizer to give lock_s (2-cycle latency).
- PLL_RST:
  - pll_rst=1 and domain_rst=all 1.
  - After RST_PULSE_CYCLES cycles, go to WAIT_LOCK; pll_rst falls on entry.
  - Clear the timeout counter on exit.
- WAIT_LOCK:
  - Timeout counter increments every cycle.
  - lock_s=1: go to FILTER with filter count=1.
  - Timeout counter reaches LOCK_TIMEOUT_CYCLES: if retry_count<MAX_RETRIES, increment retry_count and go to PLL_RST; else go to FAULT.
- FILTER:
  - Filter count increments while lock_s=1.
  - lock_s=0: go to WAIT_LOCK. The timeout counter is not cleared.
  - Timeout applies here with the same rule as WAIT_LOCK.
  - Filter count reaches LOCK_FILTER_CYCLES: go to RELEASE.
- RELEASE:
  - domain_rst[0] is cleared in the first RELEASE cycle.
  - domain_rst[i] is cleared DOMAIN_GAP_CYCLES after domain_rst[i-1].
  - After the last bit is cleared, go to RUN on the next cycle.
- RUN: ready=1 and retry_count is cleared on entry.
- Lock loss (lock_s=0 in RELEASE or RUN):
  - Next cycle: domain_rst=all 1, ready=0, state=PLL_RST.
  - retry_count is not incremented (lock loss is not a timeout).
- relock_req:
  - In RUN or RELEASE: same action as lock loss.
  - In FAULT: clear fault, clear retry_count, go to PLL_RST.
  - In PLL_RST, WAIT_LOCK or FILTER: ignored.
- FAULT: pll_rst=1, domain_rst=all 1, fault=1, held until relock_req or rst.
- Simultaneous lock loss and relock_req: treated as one re-sequence.
- Simultaneous timeout and lock_s rising: the timeout wins.
- rst mid-sequence: immediate return to reset values on the next edge, regardless of state.
- Counter widths are $clog2 of their limit + 1. Counters saturate and never wrap.

Optional Feature:
- Macro: PLL_SEQ_LOCK_LOSS_CNT_EN.
- Defined: adds output port lock_loss_cnt (16 bits). It counts lock-loss events in RELEASE/RUN (not relock_req), saturates at 0xFFFF, and is cleared only by rst.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package pll_seq_pkg: state enum (PLL_RST, WAIT_LOCK, FILTER, RELEASE, RUN, FAULT) and a saturating-increment function.
- Sub-module pll_lock_sync: 2-FF synchronizer for pll_locked, output lock_s.
- Top level: FSM and counters.

Test Plan:
All cases use NUM_DOMAINS=4, RST_PULSE_CYCLES=4, LOCK_FILTER_CYCLES=8, DOMAIN_GAP_CYCLES=2, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- Nominal: rst low at cycle 0, pll_locked rises at cycle 10 -> pll_rst falls at cycle 4; domain_rst[0] falls at cycle 21, [1] at 23, [2] at 25, [3] at 27; ready=1 at 28.
- Glitchy lock: pll_locked high 5 cycles, low 1, then high -> no domain release until 8 consecutive lock_s cycles; no retry increment.
- Timeout: pll_locked held 0 -> retry_count steps 1, then 2, then FAULT with fault=1, pll_rst=1; relock_req -> fault=0, retry_count=0, pll_rst pulse of 4 cycles.
- Lock loss in RUN: pll_locked drops -> domain_rst=4'hF and ready=0 within 3 cycles; full re-sequence follows; lock_loss_cnt=1 when the macro is defined.
- rst asserted during RELEASE with domain_rst=4'b1100 -> next cycle domain_rst=4'hF, pll_rst=1, state PLL_RST.
- relock_req in RUN together with pll_locked drop -> exactly one re-sequence; lock_loss_cnt increments by 1.
